// File: rtl/divider.sv
`default_nettype none
// ============================================================================
// Module   : divider
// Brief    : Sequential IEEE-754 single-precision divider. Restoring long
//            division producing one quotient bit per clock, with optional
//            round-to-nearest-even. Handshake and packed outputs match the
//            companion multiplier.
// Revision : 1.0  initial release
// ============================================================================
module divider (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_ready_i,
    input  logic [6:0]  rounding_mode_i,
    input  logic        x_sign_i,
    input  logic        y_sign_i,
    input  logic [7:0]  x_exp_i,
    input  logic [7:0]  y_exp_i,
    input  logic [22:0] x_frac_i,
    input  logic [22:0] y_frac_i,
    input  logic        x_infinity_i,
    input  logic        y_infinity_i,
    input  logic        x_nan_i,
    input  logic        y_nan_i,
    output logic        data_valid_o,
    output logic [31:0] z_o,
    output logic        except_invalid_operation_o,
    output logic        except_divide_by_zero_o,
    output logic        except_overflow_o,
    output logic        except_underflow_o
);

    localparam logic [3:0] S_READY     = 4'd0;
    localparam logic [3:0] S_DIVIDE    = 4'd1;
    localparam logic [3:0] S_NORMALIZE = 4'd2;
    localparam logic [3:0] S_ROUND     = 4'd3;
    localparam logic [3:0] S_VALIDATE  = 4'd4;
    localparam logic [3:0] S_DONE      = 4'd5;
    localparam logic [3:0] S_INVALID   = 4'd6;
    localparam logic [3:0] S_INF       = 4'd7;
    localparam logic [3:0] S_DBZ       = 4'd8;
    localparam logic [3:0] S_ZERO      = 4'd9;

    localparam logic [6:0] C_RNE_MODE  = 7'b0000001;

    logic [3:0]        state_q, state_d;
    logic              sign_q, sign_d;
    logic signed [9:0] exp_q, exp_d;
    logic [24:0]       rem_q, rem_d;
    logic [23:0]       div_q, div_d;
    logic [26:0]       quot_q, quot_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              rne_q, rne_d;
    logic [22:0]       frac_q, frac_d;
    logic              g_q, g_d, r_q, r_d, s_q, s_d;
    logic              valid_q, valid_d;
    logic [31:0]       z_q, z_d;
    logic              inv_q, inv_d, dbz_q, dbz_d, ovf_q, ovf_d, unf_q, unf_d;

    // Subnormal operands (exp == 0) are flushed to zero regardless of fraction
    logic w_x_zero, w_y_zero, w_invalid;
    assign w_x_zero  = (x_exp_i == 8'd0);
    assign w_y_zero  = (y_exp_i == 8'd0);
    assign w_invalid = x_nan_i | y_nan_i | (x_infinity_i & y_infinity_i) | (w_x_zero & w_y_zero);

    // One restoring-division step: trial subtract, keep it when it does not go negative
    logic        w_ge;
    logic [24:0] w_sub;
    logic [23:0] w_frac_inc;
    assign w_ge       = (rem_q >= {1'b0, div_q});
    assign w_sub      = w_ge ? (rem_q - {1'b0, div_q}) : rem_q;
    assign w_frac_inc = {1'b0, frac_q} + 24'd1;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_READY;
        else       state_q <= state_d;
    end

    // Next-state logic; special operands are classified in READY, first match wins
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_READY: begin
                if (data_ready_i) begin
                    if (w_invalid)                       state_d = S_INVALID;
                    else if (x_infinity_i)               state_d = S_INF;
                    else if (w_y_zero)                   state_d = S_DBZ;
                    else if (y_infinity_i || w_x_zero)   state_d = S_ZERO;
                    else                                 state_d = S_DIVIDE;
                end
            end
            S_DIVIDE:    if (cnt_q == 5'd0) state_d = S_NORMALIZE;
            S_NORMALIZE: state_d = S_ROUND;
            S_ROUND:     state_d = S_VALIDATE;
            S_VALIDATE:  state_d = S_DONE;
            S_INVALID, S_INF, S_DBZ, S_ZERO: state_d = S_DONE;
            S_DONE:      state_d = S_READY;
            default:     state_d = S_READY;
        endcase
    end

    // Datapath and output next-values; results are latched on the way into DONE
    always_comb begin
        sign_d  = sign_q;
        exp_d   = exp_q;
        rem_d   = rem_q;
        div_d   = div_q;
        quot_d  = quot_q;
        cnt_d   = cnt_q;
        rne_d   = rne_q;
        frac_d  = frac_q;
        g_d     = g_q;
        r_d     = r_q;
        s_d     = s_q;
        valid_d = 1'b0;
        z_d     = z_q;
        inv_d   = inv_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        case (state_q)
            S_READY: begin
                if (data_ready_i) begin
                    sign_d = x_sign_i ^ y_sign_i;
                    exp_d  = $signed({2'b00, x_exp_i}) - $signed({2'b00, y_exp_i}) + 10'sd127;
                    rem_d  = {2'b01, x_frac_i};
                    div_d  = {1'b1, y_frac_i};
                    rne_d  = (rounding_mode_i == C_RNE_MODE);
                    quot_d = 27'd0;
                    cnt_d  = 5'd26;
                end
            end
            S_DIVIDE: begin
                // Quotient bits shift in MSB first, so after 27 steps bit 26 is the first
                quot_d = {quot_q[25:0], w_ge};
                rem_d  = w_sub << 1;
                cnt_d  = cnt_q - 5'd1;
            end
            S_NORMALIZE: begin
                if (quot_q[26]) begin
                    frac_d = quot_q[25:3];
                    g_d    = quot_q[2];
                    r_d    = quot_q[1];
                    s_d    = quot_q[0] | (rem_q != 25'd0);
                end else begin
                    frac_d = quot_q[24:2];
                    g_d    = quot_q[1];
                    r_d    = quot_q[0];
                    s_d    = (rem_q != 25'd0);
                    exp_d  = exp_q - 10'sd1;
                end
            end
            S_ROUND: begin
                if (rne_q && g_q && (r_q || s_q || frac_q[0])) begin
                    frac_d = w_frac_inc[22:0];
                    if (w_frac_inc[23]) exp_d = exp_q + 10'sd1;
                end
            end
            S_VALIDATE: begin
                valid_d = 1'b1;
                inv_d   = 1'b0;
                dbz_d   = 1'b0;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
                if (exp_q >= 10'sd255) begin
                    z_d   = {sign_q, 8'hff, 23'd0};
                    ovf_d = 1'b1;
                end else if (exp_q <= 10'sd0) begin
                    z_d   = {sign_q, 31'd0};
                    unf_d = 1'b1;
                end else begin
                    z_d   = {sign_q, exp_q[7:0], frac_q};
                end
            end
            S_INVALID, S_INF, S_DBZ, S_ZERO: begin
                valid_d = 1'b1;
                inv_d   = (state_q == S_INVALID);
                dbz_d   = (state_q == S_DBZ);
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
                if (state_q == S_INVALID)   z_d = 32'h7fffffff;
                else if (state_q == S_ZERO) z_d = {sign_q, 31'd0};
                else                        z_d = {sign_q, 8'hff, 23'd0};
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sign_q  <= 1'b0;
            exp_q   <= 10'sd0;
            rem_q   <= 25'd0;
            div_q   <= 24'd0;
            quot_q  <= 27'd0;
            cnt_q   <= 5'd0;
            rne_q   <= 1'b0;
            frac_q  <= 23'd0;
            g_q     <= 1'b0;
            r_q     <= 1'b0;
            s_q     <= 1'b0;
            valid_q <= 1'b0;
            z_q     <= 32'd0;
            inv_q   <= 1'b0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            quot_q  <= quot_d;
            cnt_q   <= cnt_d;
            rne_q   <= rne_d;
            frac_q  <= frac_d;
            g_q     <= g_d;
            r_q     <= r_d;
            s_q     <= s_d;
            valid_q <= valid_d;
            z_q     <= z_d;
            inv_q   <= inv_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign data_valid_o               = valid_q;
    assign z_o                        = z_q;
    assign except_invalid_operation_o = inv_q;
    assign except_divide_by_zero_o    = dbz_q;
    assign except_overflow_o          = ovf_q;
    assign except_underflow_o         = unf_q;

endmodule
`default_nettype wire
